// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage_if
//  Brief    : Decode-to-operand-stage request bundle. Decode drives the
//             instruction fields and ID_valid; the operand stage answers with
//             ID_ready.
//  Revision : 1.0  initial release
// ============================================================================
interface id_ex_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            ID_valid;
    logic            ID_ready;
    logic [4:0]      ID_Rs1;
    logic [4:0]      ID_Rs2;
    logic [4:0]      ID_Rd;
    logic            ID_RegWrite;
    logic            ID_MemRead;
    logic [XLEN-1:0] ID_Imm;

    // Decode side: offers an instruction, observes acceptance
    modport master (
        output ID_valid, ID_Rs1, ID_Rs2, ID_Rd, ID_RegWrite, ID_MemRead, ID_Imm,
        input  ID_ready
    );

    // Operand stage side: consumes the instruction, reports acceptance
    modport slave (
        input  ID_valid, ID_Rs1, ID_Rs2, ID_Rd, ID_RegWrite, ID_MemRead, ID_Imm,
        output ID_ready
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Brief    : ID->EX pipeline register. Resolves source operands with MEM/WB
//             forwarding, detects load-use hazards against EX and MEM,
//             inserts bubbles, and counts load-use stall cycles (saturating).
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,

    id_ex_operand_stage_if.slave        id,

    input  wire logic [XLEN-1:0]        Read_data1,
    input  wire logic [XLEN-1:0]        Read_data2,

    input  wire logic [4:0]             MEM_Rd,
    input  wire logic                   MEM_RegWrite,
    input  wire logic                   MEM_MemRead,
    input  wire logic [XLEN-1:0]        MEM_Result,

    input  wire logic [4:0]             WB_Rd,
    input  wire logic                   WB_RegWrite,
    input  wire logic [XLEN-1:0]        WB_Result,

    input  wire logic                   Flush,
    input  wire logic                   EX_ready,

    output logic                        EX_valid,
    output logic [XLEN-1:0]             EX_Op1,
    output logic [XLEN-1:0]             EX_Op2,
    output logic [4:0]                  EX_Rd,
    output logic                        EX_RegWrite,
    output logic                        EX_MemRead,
    output logic [XLEN-1:0]             EX_Imm,

    output logic                        Load_use_stall,
    output logic [STALL_CNT_W-1:0]      Stall_count
);

    localparam logic [4:0]             c_REG_ZERO = 5'd0;
    localparam logic [STALL_CNT_W-1:0] c_CNT_MAX  = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] c_CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // EX-stage state
    // ------------------------------------------------------------------------
    logic                   ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]        ex_op1_q,      ex_op1_d;
    logic [XLEN-1:0]        ex_op2_q,      ex_op2_d;
    logic [4:0]             ex_rd_q,       ex_rd_d;
    logic                   ex_regwrite_q, ex_regwrite_d;
    logic                   ex_memread_q,  ex_memread_d;
    logic [XLEN-1:0]        ex_imm_q,      ex_imm_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic [XLEN-1:0]        w_op1;
    logic [XLEN-1:0]        w_op2;
    logic                   w_haz1;
    logic                   w_haz2;
    logic                   w_load_use_stall;
    logic                   w_ex_free;
    logic                   w_id_ready;
    logic                   w_transfer;

    // Forwarding mux: x0 is hard zero, then the younger MEM result (only if it
    // is not a load, whose data is not available yet), then WB, then regfile.
    // WB must be forwarded because the regfile write happens on the same cycle.
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic [4:0]      mem_rd,
        input logic            mem_regwrite,
        input logic            mem_memread,
        input logic [XLEN-1:0] mem_result,
        input logic [4:0]      wb_rd,
        input logic            wb_regwrite,
        input logic [XLEN-1:0] wb_result
    );
        logic [XLEN-1:0] val;
        if (rs == c_REG_ZERO) begin
            val = '0;
        end else if (mem_regwrite && !mem_memread && (mem_rd == rs)) begin
            val = mem_result;
        end else if (wb_regwrite && (wb_rd == rs)) begin
            val = wb_result;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Load-use check for one source: a load in EX or in MEM targeting rs.
    function automatic logic load_use_hit(
        input logic [4:0] rs,
        input logic       ex_valid,
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] mem_rd,
        input logic       mem_regwrite,
        input logic       mem_memread
    );
        logic hit;
        hit = 1'b0;
        if (rs != c_REG_ZERO) begin
            hit = (ex_valid && ex_memread && (ex_rd == rs)) ||
                  (mem_memread && mem_regwrite && (mem_rd == rs));
        end
        return hit;
    endfunction

    // Operand resolution and hazard/handshake decisions for the decode slot
    always_comb begin
        w_op1 = resolve_operand(id.ID_Rs1, Read_data1, MEM_Rd, MEM_RegWrite,
                                MEM_MemRead, MEM_Result, WB_Rd, WB_RegWrite, WB_Result);
        w_op2 = resolve_operand(id.ID_Rs2, Read_data2, MEM_Rd, MEM_RegWrite,
                                MEM_MemRead, MEM_Result, WB_Rd, WB_RegWrite, WB_Result);

        w_haz1 = load_use_hit(id.ID_Rs1, ex_valid_q, ex_memread_q, ex_rd_q,
                              MEM_Rd, MEM_RegWrite, MEM_MemRead);
        w_haz2 = load_use_hit(id.ID_Rs2, ex_valid_q, ex_memread_q, ex_rd_q,
                              MEM_Rd, MEM_RegWrite, MEM_MemRead);

        // A flush overrides the hazard: the dependent instruction is killed
        // upstream anyway, so no bubble is requested or counted.
        w_load_use_stall = id.ID_valid && (w_haz1 || w_haz2) && !Flush;

        // EX slot can take a new entry when empty or being drained this cycle
        w_ex_free  = !ex_valid_q || EX_ready;
        w_id_ready = w_ex_free && !w_load_use_stall && !Flush;
        w_transfer = id.ID_valid && w_id_ready;
    end

    // Next-state for the EX register: flush, then capture, then drain, else hold
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_op1_d      = ex_op1_q;
        ex_op2_d      = ex_op2_q;
        ex_rd_d       = ex_rd_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_imm_d      = ex_imm_q;

        if (Flush) begin
            ex_valid_d = 1'b0;
        end else if (w_transfer) begin
            ex_valid_d    = 1'b1;
            ex_op1_d      = w_op1;
            ex_op2_d      = w_op2;
            ex_rd_d       = id.ID_Rd;
            ex_regwrite_d = id.ID_RegWrite;
            ex_memread_d  = id.ID_MemRead;
            ex_imm_d      = id.ID_Imm;
        end else if (w_ex_free) begin
            ex_valid_d = 1'b0;
        end
    end

    // Stall counter counts only bubbles actually inserted (not backpressure)
    always_comb begin
        stall_count_d = stall_count_q;
        if (w_load_use_stall && w_ex_free && (stall_count_q != c_CNT_MAX)) begin
            stall_count_d = stall_count_q + c_CNT_ONE;
        end
    end

    // EX-stage register and stall counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_imm_q      <= '0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_imm_q      <= ex_imm_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign id.ID_ready      = w_id_ready;
    assign Load_use_stall   = w_load_use_stall;
    assign EX_valid         = ex_valid_q;
    assign EX_Op1           = ex_op1_q;
    assign EX_Op2           = ex_op2_q;
    assign EX_Rd            = ex_rd_q;
    assign EX_RegWrite      = ex_regwrite_q;
    assign EX_MemRead       = ex_memread_q;
    assign EX_Imm           = ex_imm_q;
    assign Stall_count      = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Brief    : Self-checking bench for id_ex_operand_stage. A cycle model
//             predicts handshake/hazard outputs; captured payloads are queued
//             and compared while they sit in the EX register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_operand_stage;

    localparam int XLEN   = 32;
    localparam int CNT_W  = 8;   // narrow counter so saturation is reachable quickly
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
    } ex_entry_t;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  Read_data1, Read_data2;
    logic [4:0]       MEM_Rd;
    logic             MEM_RegWrite, MEM_MemRead;
    logic [XLEN-1:0]  MEM_Result;
    logic [4:0]       WB_Rd;
    logic             WB_RegWrite;
    logic [XLEN-1:0]  WB_Result;
    logic             Flush, EX_ready;
    logic             EX_valid;
    logic [XLEN-1:0]  EX_Op1, EX_Op2, EX_Imm;
    logic [4:0]       EX_Rd;
    logic             EX_RegWrite, EX_MemRead;
    logic             Load_use_stall;
    logic [CNT_W-1:0] Stall_count;

    id_ex_operand_stage_if #(.XLEN(XLEN)) id_if ();

    id_ex_operand_stage #(.XLEN(XLEN), .STALL_CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id             (id_if.slave),
        .Read_data1     (Read_data1),
        .Read_data2     (Read_data2),
        .MEM_Rd         (MEM_Rd),
        .MEM_RegWrite   (MEM_RegWrite),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_Result     (MEM_Result),
        .WB_Rd          (WB_Rd),
        .WB_RegWrite    (WB_RegWrite),
        .WB_Result      (WB_Result),
        .Flush          (Flush),
        .EX_ready       (EX_ready),
        .EX_valid       (EX_valid),
        .EX_Op1         (EX_Op1),
        .EX_Op2         (EX_Op2),
        .EX_Rd          (EX_Rd),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .EX_Imm         (EX_Imm),
        .Load_use_stall (Load_use_stall),
        .Stall_count    (Stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic             m_valid;
    logic             m_mr;
    logic [4:0]       m_rd;
    logic [CNT_W-1:0] m_cnt;
    ex_entry_t        sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 5'd0)                                          return '0;
        if (MEM_RegWrite && !MEM_MemRead && MEM_Rd == rs)        return MEM_Result;
        if (WB_RegWrite && WB_Rd == rs)                          return WB_Result;
        return rf;
    endfunction

    function automatic logic m_hit(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        return (m_valid && m_mr && m_rd == rs) ||
               (MEM_MemRead && MEM_RegWrite && MEM_Rd == rs);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_mr    = 1'b0;
        m_rd    = '0;
        m_cnt   = '0;
        sb_q.delete();
    endtask

    task automatic set_idle();
        id_if.ID_valid    = 1'b0;
        id_if.ID_Rs1      = '0;
        id_if.ID_Rs2      = '0;
        id_if.ID_Rd       = '0;
        id_if.ID_RegWrite = 1'b0;
        id_if.ID_MemRead  = 1'b0;
        id_if.ID_Imm      = '0;
        Read_data1 = '0;  Read_data2 = '0;
        MEM_Rd = '0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_Result = '0;
        WB_Rd  = '0; WB_RegWrite  = 1'b0; WB_Result  = '0;
        Flush = 1'b0; EX_ready = 1'b1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic [XLEN-1:0] imm);
        id_if.ID_valid    = 1'b1;
        id_if.ID_Rs1      = rs1;
        id_if.ID_Rs2      = rs2;
        id_if.ID_Rd       = rd;
        id_if.ID_RegWrite = rw;
        id_if.ID_MemRead  = mr;
        id_if.ID_Imm      = imm;
    endtask

    // Called right after inputs change at negedge: check, advance model, wait.
    task automatic step();
        logic      haz, stall, ready, xfer, free;
        ex_entry_t e;
        #1;
        haz   = id_if.ID_valid && (m_hit(id_if.ID_Rs1) || m_hit(id_if.ID_Rs2));
        stall = haz && !Flush;
        free  = !m_valid || EX_ready;
        ready = free && !stall && !Flush;
        xfer  = id_if.ID_valid && ready;

        check_eq("Load_use_stall", 64'(Load_use_stall), 64'(stall));
        check_eq("ID_ready",       64'(id_if.ID_ready), 64'(ready));
        check_eq("EX_valid",       64'(EX_valid),       64'(m_valid));
        check_eq("Stall_count",    64'(Stall_count),    64'(m_cnt));
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("scoreboard_empty", 64'(0), 64'(1));
            end else begin
                e = sb_q[0];
                check_eq("EX_Op1",      64'(EX_Op1),      64'(e.op1));
                check_eq("EX_Op2",      64'(EX_Op2),      64'(e.op2));
                check_eq("EX_Imm",      64'(EX_Imm),      64'(e.imm));
                check_eq("EX_Rd",       64'(EX_Rd),       64'(e.rd));
                check_eq("EX_RegWrite", 64'(EX_RegWrite), 64'(e.rw));
                check_eq("EX_MemRead",  64'(EX_MemRead),  64'(e.mr));
            end
        end

        // Model update for the coming posedge
        if (stall && free && m_cnt != c_CNT_MAX) m_cnt = m_cnt + 1'b1;
        if (Flush) begin
            if (m_valid && sb_q.size() > 0) void'(sb_q.pop_front());
            m_valid = 1'b0;
        end else if (xfer) begin
            if (m_valid && sb_q.size() > 0) void'(sb_q.pop_front());
            e.op1 = m_resolve(id_if.ID_Rs1, Read_data1);
            e.op2 = m_resolve(id_if.ID_Rs2, Read_data2);
            e.imm = id_if.ID_Imm;
            e.rd  = id_if.ID_Rd;
            e.rw  = id_if.ID_RegWrite;
            e.mr  = id_if.ID_MemRead;
            sb_q.push_back(e);
            m_valid = 1'b1;
            m_mr    = id_if.ID_MemRead;
            m_rd    = id_if.ID_Rd;
        end else if (free) begin
            if (m_valid && sb_q.size() > 0) void'(sb_q.pop_front());
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_EX_valid", 64'(EX_valid),    64'(0));
        check_eq("rst_EX_Op1",   64'(EX_Op1),      64'(0));
        check_eq("rst_EX_Op2",   64'(EX_Op2),      64'(0));
        check_eq("rst_EX_Imm",   64'(EX_Imm),      64'(0));
        check_eq("rst_EX_Rd",    64'(EX_Rd),       64'(0));
        check_eq("rst_EX_ctl",   64'({EX_RegWrite, EX_MemRead}), 64'(0));
        check_eq("rst_Stall",    64'(Stall_count), 64'(0));
        rst_n = 1'b1;

        // 1: plain capture from the register file
        set_id(5'd5, 5'd6, 5'd9, 1'b1, 1'b0, 32'h100);
        Read_data1 = 32'h11; Read_data2 = 32'h22;
        step();
        set_idle(); step();

        // 2: MEM beats WB; x0 is always zero even with matching producers
        set_id(5'd5, 5'd6, 5'd3, 1'b1, 1'b0, 32'h200);
        Read_data1 = 32'h55; Read_data2 = 32'h66;
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd5; MEM_Result = 32'hAA;
        WB_RegWrite  = 1'b1; WB_Rd  = 5'd5; WB_Result  = 32'hBB;
        step();
        set_id(5'd0, 5'd5, 5'd3, 1'b1, 1'b0, 32'h201);
        MEM_Rd = 5'd0; WB_Rd = 5'd0;
        step();
        set_id(5'd6, 5'd0, 5'd4, 1'b0, 1'b0, 32'h202);   // WB-only forward on Rs1
        WB_Rd = 5'd6; WB_Result = 32'hC6; MEM_Rd = 5'd9;
        step();
        set_idle(); step();

        // 3: load to x7 in EX, dependent follows -> two bubbles, then WB forward
        set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h4);
        Read_data1 = 32'h1000;
        step();
        set_id(5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 32'h0);   // load in EX
        Read_data1 = 32'hDEAD;
        step();
        MEM_Rd = 5'd7; MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1;   // load in MEM
        step();
        MEM_Rd = 5'd0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0;   // load in WB
        WB_Rd = 5'd7; WB_RegWrite = 1'b1; WB_Result = 32'h77;
        step();
        check_eq("stall_after_load_use", 64'(m_cnt), 64'(2));
        set_idle(); step();

        // 4: backpressure holds payload and blocks decode without counting
        set_id(5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'h400);
        Read_data1 = 32'h33; Read_data2 = 32'h44;
        step();
        EX_ready = 1'b0;
        set_id(5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 32'h401);
        Read_data1 = 32'h9; Read_data2 = 32'hA;
        repeat (3) step();
        EX_ready = 1'b1;
        step();
        set_idle(); step();

        // 5: flush with valid decode and valid EX; flush masks a hazard
        set_id(5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 32'h500);
        step();
        set_id(5'd2, 5'd3, 5'd15, 1'b1, 1'b0, 32'h501);
        Flush = 1'b1;
        step();
        MEM_Rd = 5'd2; MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1;
        step();
        Flush = 1'b0; set_idle(); step();

        // Random traffic with small register range to provoke collisions
        for (int i = 0; i < 300; i++) begin
            id_if.ID_valid    = ($urandom_range(0, 3) != 0);
            id_if.ID_Rs1      = 5'($urandom_range(0, 7));
            id_if.ID_Rs2      = 5'($urandom_range(0, 7));
            id_if.ID_Rd       = 5'($urandom_range(0, 7));
            id_if.ID_RegWrite = 1'($urandom_range(0, 1));
            id_if.ID_MemRead  = ($urandom_range(0, 2) == 0);
            id_if.ID_Imm      = $urandom;
            Read_data1 = $urandom; Read_data2 = $urandom;
            MEM_Rd = 5'($urandom_range(0, 7)); MEM_RegWrite = 1'($urandom_range(0, 1));
            MEM_MemRead = ($urandom_range(0, 2) == 0); MEM_Result = $urandom;
            WB_Rd = 5'($urandom_range(0, 7)); WB_RegWrite = 1'($urandom_range(0, 1));
            WB_Result = $urandom;
            Flush    = ($urandom_range(0, 9) == 0);
            EX_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        set_idle(); step();

        // 6: sustained MEM load hazard drives the counter into saturation
        set_id(5'd9, 5'd0, 5'd1, 1'b1, 1'b0, 32'h600);
        MEM_Rd = 5'd9; MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1;
        repeat ((1 << CNT_W) + 8) step();
        check_eq("Stall_count_saturated", 64'(Stall_count), 64'(c_CNT_MAX));
        set_idle();
        set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h601);
        step();
        set_idle();
        #2;
        rst_n = 1'b0;          // asynchronous, away from any clock edge
        #1;
        check_eq("async_rst_EX_valid", 64'(EX_valid),    64'(0));
        check_eq("async_rst_Stall",    64'(Stall_count), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
